tim1_time_base: RTL and testbench

Timer-1 time-base unit. It consumes the 8-bit TIM1 control word (CR1) and runs the 16-bit prescaler, the auto-reload logic and the counter. It generates update events (UEV) and update-interrupt-flag set pulses for the status and compare stages downstream.
It also requests CEN clear in one-pulse mode. The CR1 register block performs the actual clear.

---
 rtl/tim1_pkg.sv | 27 ++
 rtl/tim1_time_base_prescaler.sv | 38 +++
 rtl/tim1_time_base.sv | 142 ++++++++++++++
 tb/tb_tim1_time_base.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim1_pkg.sv
// Shared constants for the TIM1 time-base slice: CR1 bit positions,
// centre-mode encodings and the counting-phase state type.
package tim1_pkg;

  localparam int CNT_W_DEF = 16;

  localparam int CR1_CEN     = 0;
  localparam int CR1_UDIS    = 1;
  localparam int CR1_URS     = 2;
  localparam int CR1_OPM     = 3;
  localparam int CR1_DIR     = 4;
  localparam int CR1_CMS_LSB = 5;
  localparam int CR1_ARPE    = 7;

  typedef enum logic [1:0] {
    CMS_EDGE    = 2'b00,
    CMS_CENTER1 = 2'b01,
    CMS_CENTER2 = 2'b10,
    CMS_CENTER3 = 2'b11
  } cms_e;

  typedef enum logic {
    PH_UP   = 1'b0,
    PH_DOWN = 1'b1
  } phase_e;

endpackage

// File: rtl/tim1_time_base_prescaler.sv
// Prescaler: divides the kernel clock by psc_shadow+1 while running.
// psc_shadow is only reloaded on an update event, so PSC is always preloaded.
module tim1_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ug,
  input  logic             load,
  input  logic [CNT_W-1:0] psc,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] psc_cnt;
  logic [CNT_W-1:0] psc_shadow;

  assign tick = run & (psc_cnt == psc_shadow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt    <= '0;
      psc_shadow <= '0;
    end else begin
      if (ug || tick) begin
        psc_cnt <= '0;
      end else if (run) begin
        psc_cnt <= psc_cnt + ONE;
      end
      if (load) begin
        psc_shadow <= psc;
      end
    end
  end

endmodule

// File: rtl/tim1_time_base.sv
// TIM1 time-base: prescaler, ARR preload/shadow, edge and centre-aligned
// counter, registered update/UIF pulses and the one-pulse-mode CEN-clear request.
module tim1_time_base
  import tim1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_cr1,
  input  logic [CNT_W-1:0] i_psc,
  input  logic             i_arr_wr,
  input  logic [CNT_W-1:0] i_arr_wdata,
  input  logic             i_ug,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_dir,
  output logic             o_uev,
  output logic             o_uif_set,
  output logic             o_cen_clr,
  output logic [CNT_W-1:0] o_arr
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             cen, udis, urs, opm, dir_bit, arpe, center;
  cms_e             cms;
  logic             run, tick, opm_halt;
  logic [CNT_W-1:0] arr_pre, arr_shadow, arr_active;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wrap, turn_up, turn_down, eff_down;
  logic             uev_now, uif_now, cen_clr_now;
  phase_e           phase, phase_nxt;

  assign cen     = i_cr1[CR1_CEN];
  assign udis    = i_cr1[CR1_UDIS];
  assign urs     = i_cr1[CR1_URS];
  assign opm     = i_cr1[CR1_OPM];
  assign dir_bit = i_cr1[CR1_DIR];
  assign arpe    = i_cr1[CR1_ARPE];
  assign cms     = cms_e'(i_cr1[CR1_CMS_LSB +: 2]);
  assign center  = (cms != CMS_EDGE);

  assign run        = cen & ~opm_halt;
  assign arr_active = arpe ? arr_shadow : arr_pre;

  tim1_prescaler #(.CNT_W(CNT_W)) u_psc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .ug   (i_ug),
    .load (uev_now),
    .psc  (i_psc),
    .tick (tick)
  );

  // Centre-mode phase: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_UP;
    else     phase <= phase_nxt;
  end

  // Centre-mode phase: next state.
  always_comb begin
    phase_nxt = phase;
    if (i_ug) begin
      if (center) phase_nxt = PH_UP;
    end else if (turn_down) begin
      phase_nxt = PH_DOWN;
    end else if (turn_up) begin
      phase_nxt = PH_UP;
    end
  end

  // Centre-mode phase: outputs. Edge mode takes the direction from CR1.DIR.
  always_comb begin
    o_dir    = center ? (phase == PH_DOWN) : dir_bit;
    eff_down = o_dir;
  end

  // Counter next value; wrap flags an overflow or underflow on this tick.
  always_comb begin
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    turn_up   = 1'b0;
    turn_down = 1'b0;
    if (i_ug) begin
      cnt_nxt = (!center && dir_bit) ? arr_active : '0;
    end else if (tick) begin
      if (arr_active == '0) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else if (eff_down) begin
        if (cnt == '0) begin
          wrap    = 1'b1;
          cnt_nxt = center ? ONE : arr_active;
          turn_up = center;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end else begin
        // A value above ARR simply keeps counting and rolls over silently.
        if (cnt == arr_active) begin
          wrap      = 1'b1;
          cnt_nxt   = center ? (arr_active - ONE) : '0;
          turn_down = center;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
    end
  end

  assign uev_now     = (wrap | i_ug) & ~udis;
  assign uif_now     = uev_now & ~(i_ug & urs);
  assign cen_clr_now = opm & wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      arr_pre    <= '0;
      arr_shadow <= '0;
      opm_halt   <= 1'b0;
      o_uev      <= 1'b0;
      o_uif_set  <= 1'b0;
      o_cen_clr  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      o_uev     <= uev_now;
      o_uif_set <= uif_now;
      o_cen_clr <= cen_clr_now;
      if (i_arr_wr) arr_pre <= i_arr_wdata;
      // A write landing with the update event bypasses straight into the shadow.
      if (uev_now) arr_shadow <= i_arr_wr ? i_arr_wdata : arr_pre;
      if (!cen)             opm_halt <= 1'b0;
      else if (cen_clr_now) opm_halt <= 1'b1;
    end
  end

  assign o_cnt = cnt;
  assign o_arr = arr_active;

endmodule

// File: tb/tb_tim1_time_base.sv
// Bench for tim1_time_base: directed scenarios with literal expectations plus
// randomized CR1/ARR/UG traffic, all checked every cycle against a rule model.
module tb_tim1_time_base;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   i_cr1 = '0;
  logic [W-1:0] i_psc = '0;
  logic         i_arr_wr = 1'b0;
  logic [W-1:0] i_arr_wdata = '0;
  logic         i_ug = 1'b0;
  logic [W-1:0] o_cnt;
  logic         o_dir, o_uev, o_uif_set, o_cen_clr;
  logic [W-1:0] o_arr;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_cnt = 0, m_pc = 0, m_psc = 0, m_pre = 0, m_sh = 0;
  bit m_down = 0, m_halt = 0, e_uev = 0, e_uif = 0, e_clr = 0;

  tim1_time_base #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .i_cr1(i_cr1), .i_psc(i_psc),
    .i_arr_wr(i_arr_wr), .i_arr_wdata(i_arr_wdata), .i_ug(i_ug),
    .o_cnt(o_cnt), .o_dir(o_dir), .o_uev(o_uev), .o_uif_set(o_uif_set),
    .o_cen_clr(o_cen_clr), .o_arr(o_arr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Rule model: what the timer must do on each kernel clock edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_pc = 0; m_psc = 0; m_pre = 0; m_sh = 0;
        m_down = 0; m_halt = 0; e_uev = 0; e_uif = 0; e_clr = 0;
      end else begin
        int arr;
        bit center, run, tk, wrap;
        arr    = i_cr1[7] ? m_sh : m_pre;
        center = (i_cr1[6:5] != 2'b00);
        run    = i_cr1[0] && !m_halt;
        tk     = run && (m_pc == m_psc);
        wrap   = 0;
        if (i_ug) begin
          m_pc  = 0;
          m_cnt = (!center && i_cr1[4]) ? arr : 0;
          if (center) m_down = 0;
        end else begin
          if (tk) m_pc = 0;
          else if (run) m_pc = m_pc + 1;
          if (tk) begin
            if (arr == 0) begin
              m_cnt = 0; wrap = 1;
            end else if (center ? m_down : i_cr1[4]) begin
              if (m_cnt == 0) begin
                wrap = 1;
                m_cnt = center ? 1 : arr;
                if (center) m_down = 0;
              end else m_cnt = m_cnt - 1;
            end else begin
              if (m_cnt == arr) begin
                wrap = 1;
                m_cnt = center ? arr - 1 : 0;
                if (center) m_down = 1;
              end else m_cnt = (m_cnt + 1) % 65536;
            end
          end
        end
        e_uev = (wrap || i_ug) && !i_cr1[1];
        e_uif = e_uev && !(i_ug && i_cr1[2]);
        e_clr = i_cr1[3] && wrap;
        if (e_uev) begin
          m_psc = int'(i_psc);
          m_sh  = i_arr_wr ? int'(i_arr_wdata) : m_pre;
        end
        if (i_arr_wr) m_pre = int'(i_arr_wdata);
        if (!i_cr1[0]) m_halt = 0;
        else if (e_clr) m_halt = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: outputs compared with the model at the falling edge,
  // then control returns 1 time unit later so inputs never race the sample.
  task automatic step();
    bit center;
    @(posedge clk);
    @(negedge clk);
    center = (i_cr1[6:5] != 2'b00);
    check("cnt", 32'(o_cnt), 32'(m_cnt));
    check("dir", 32'(o_dir), 32'(center ? m_down : i_cr1[4]));
    check("uev", 32'(o_uev), 32'(e_uev));
    check("uif", 32'(o_uif_set), 32'(e_uif));
    check("cen_clr", 32'(o_cen_clr), 32'(e_clr));
    check("arr", 32'(o_arr), 32'(i_cr1[7] ? m_sh : m_pre));
    #1;
  endtask

  task automatic write_arr(input int v);
    i_arr_wr = 1'b1; i_arr_wdata = W'(v);
    step();
    i_arr_wr = 1'b0;
  endtask

  task automatic pulse_ug();
    i_ug = 1'b1;
    step();
    i_ug = 1'b0;
  endtask

  task automatic run_until_cnt(input int v, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'(o_cnt) == v) begin found = 1; break; end
      step();
    end
    check("wait_cnt", 32'(found), 32'd1);
  endtask

  int seq_up[9]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int seq_dn[6]   = '{4, 3, 2, 1, 0, 4};
  int seq_c[8]    = '{0, 1, 2, 3, 2, 1, 0, 1};
  int dir_c[8]    = '{0, 0, 0, 0, 1, 1, 1, 0};
  int uev_c[8]    = '{1, 0, 0, 0, 1, 0, 0, 1};
  int seq_arpe[8] = '{6, 7, 8, 9, 0, 1, 2, 0};

  initial begin
    // Reset state
    step(); step();
    check("rst_cnt", 32'(o_cnt), 0);
    check("rst_uev", 32'(o_uev), 0);
    check("rst_uif", 32'(o_uif_set), 0);
    check("rst_clr", 32'(o_cen_clr), 0);
    check("rst_arr", 32'(o_arr), 0);
    check("rst_dir", 32'(o_dir), 0);
    rst = 1'b0;
    step();

    // Edge up, PSC=1, ARR=3: period 8 clocks
    i_psc = 1;
    write_arr(3);
    i_cr1 = 8'h01;
    pulse_ug();
    check("up_cnt0", 32'(o_cnt), 0);
    check("up_uev0", 32'(o_uev), 1);
    for (int i = 1; i < 9; i++) begin
      step();
      check("up_seq", 32'(o_cnt), 32'(seq_up[i]));
      check("up_uev", 32'(o_uev), 32'(i == 8));
      check("up_uif", 32'(o_uif_set), 32'(i == 8));
    end

    // Edge down, PSC=0, ARR=4
    i_cr1 = 8'h00; i_psc = 0;
    write_arr(4);
    i_cr1 = 8'h11;
    pulse_ug();
    check("dn_cnt0", 32'(o_cnt), 4);
    for (int i = 1; i < 6; i++) begin
      step();
      check("dn_seq", 32'(o_cnt), 32'(seq_dn[i]));
      check("dn_uev", 32'(o_uev), 32'(i == 5));
    end
    i_cr1 = 8'h13;
    for (int i = 0; i < 12; i++) begin
      step();
      check("udis_uev", 32'(o_uev), 0);
      check("udis_uif", 32'(o_uif_set), 0);
    end

    // Centre-aligned mode 1, ARR=3
    i_cr1 = 8'h00;
    write_arr(3);
    i_cr1 = 8'h21;
    pulse_ug();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      check("c_cnt", 32'(o_cnt), 32'(seq_c[i]));
      check("c_dir", 32'(o_dir), 32'(dir_c[i]));
      check("c_uev", 32'(o_uev), 32'(uev_c[i]));
    end

    // ARPE=1: new ARR waits for the update event
    i_cr1 = 8'h00;
    write_arr(9);
    i_cr1 = 8'h81;
    pulse_ug();
    run_until_cnt(5, 20);
    write_arr(2);
    check("arpe_arr_old", 32'(o_arr), 9);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      check("arpe_seq", 32'(o_cnt), 32'(seq_arpe[i]));
    end
    check("arpe_arr_new", 32'(o_arr), 2);

    // ARPE=0: lowered ARR takes effect next cycle
    i_cr1 = 8'h00;
    write_arr(9);
    i_cr1 = 8'h01;
    pulse_ug();
    run_until_cnt(1, 20);
    write_arr(2);
    check("noarpe_cnt", 32'(o_cnt), 2);
    check("noarpe_arr", 32'(o_arr), 2);
    step();
    check("noarpe_wrap", 32'(o_cnt), 0);
    check("noarpe_uev", 32'(o_uev), 1);

    // UG with URS=1 and URS=0
    write_arr(9);
    i_cr1 = 8'h05;
    pulse_ug();
    run_until_cnt(7, 20);
    pulse_ug();
    check("urs1_cnt", 32'(o_cnt), 0);
    check("urs1_uev", 32'(o_uev), 1);
    check("urs1_uif", 32'(o_uif_set), 0);
    i_cr1 = 8'h01;
    run_until_cnt(7, 20);
    pulse_ug();
    check("urs0_uif", 32'(o_uif_set), 1);

    // One-pulse mode, ARR=2
    i_cr1 = 8'h00;
    write_arr(2);
    i_cr1 = 8'h09;
    pulse_ug();
    for (int i = 1; i < 4; i++) begin
      step();
      check("opm_seq", 32'(o_cnt), 32'(i % 3));
      check("opm_clr", 32'(o_cen_clr), 32'(i == 3));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("opm_hold", 32'(o_cnt), 0);
      check("opm_clr_once", 32'(o_cen_clr), 0);
    end
    i_cr1 = 8'h00; step();
    i_cr1 = 8'h09; step();
    check("opm_resume", 32'(o_cnt), 1);

    // Asynchronous reset in the middle of counting
    write_arr(9);
    i_cr1 = 8'h01;
    pulse_ug();
    run_until_cnt(4, 20);
    rst = 1'b1;
    #1;
    check("mrst_cnt", 32'(o_cnt), 0);
    check("mrst_arr", 32'(o_arr), 0);
    check("mrst_uev", 32'(o_uev), 0);
    check("mrst_uif", 32'(o_uif_set), 0);
    step();
    rst = 1'b0;
    step();

    // Randomized traffic
    i_cr1 = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        i_cr1 = 8'($urandom_range(0, 255));
        i_cr1[0] = ($urandom_range(0, 7) != 0);
      end
      i_psc       = W'($urandom_range(0, 3));
      i_arr_wr    = ($urandom_range(0, 29) == 0);
      i_arr_wdata = W'($urandom_range(0, 12));
      i_ug        = ($urandom_range(0, 24) == 0);
      step();
    end
    i_arr_wr = 1'b0; i_ug = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
